// File: rtl/func_arb_pkg.sv
// Shared types and helpers for the functionality grant arbiter.
// Used with and without FUNC_ARB_RR_EN.
package func_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_BLOCK = 2'd2
   } arb_state_e;

   localparam logic [2:0] FUNC_CODE_DEF = 3'b010;

   // True when no more than one bit of v is set
   function automatic logic at_most_one(input logic [15:0] v);
      return (v & (v - 16'd1)) == 16'd0;
   endfunction

endpackage

// File: rtl/func_grant_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after last_ptr_i.
// Instantiated by func_grant_arbiter only when FUNC_ARB_RR_EN is defined.
module rr_pick #(
   parameter int N_CH  = 2,
   parameter int IDX_W = 1
) (
   input  logic [N_CH-1:0]  req_i,
   input  logic [IDX_W-1:0] last_ptr_i,
   output logic [N_CH-1:0]  pick_o,
   output logic [IDX_W-1:0] idx_o
);

   int   cand;
   logic found;

   always_comb begin
      pick_o = '0;
      idx_o  = '0;
      found  = 1'b0;
      cand   = 0;
      for (int off = 1; off <= N_CH; off++) begin
         cand = (int'(last_ptr_i) + off) % N_CH;
         if (!found && req_i[cand]) begin
            found        = 1'b1;
            pick_o[cand] = 1'b1;
            idx_o        = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/func_grant_arbiter.sv
// Registered owner arbiter for one shared functionality with conflict count.
// FUNC_ARB_RR_EN: round-robin conflict resolution and HOLD_MAX handover.
module func_grant_arbiter
   import func_arb_pkg::*;
#(
   parameter int              N_CH      = 2,
   parameter int              MODE_W    = 3,
   parameter logic [MODE_W-1:0] FUNC_CODE = FUNC_CODE_DEF,
   parameter int              HOLD_MAX  = 15,
   parameter int              CNT_W     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_CH*MODE_W-1:0]   mode_i,
   output logic [N_CH-1:0]          grant_o,
   output logic                     busy_o,
   output logic                     conflict_o,
   output logic [CNT_W-1:0]         conflict_cnt_o
);

   arb_state_e       state_q;
   logic [N_CH-1:0]  grant_q;
   logic             conflict_q;
   logic [CNT_W-1:0] cnt_q;
   logic [N_CH-1:0]  req;
   logic             own_req;
   logic             multi;

   always_comb begin
      req = '0;
      for (int i = 0; i < N_CH; i++) begin
         req[i] = (mode_i[i*MODE_W +: MODE_W] == FUNC_CODE);
      end
   end

   assign own_req = |(req & grant_q);
   assign multi   = !at_most_one(16'(req));

`ifdef FUNC_ARB_RR_EN
   localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int HOLD_W = $clog2(HOLD_MAX + 1);

   logic [IDX_W-1:0]  last_ptr_q;
   logic [HOLD_W-1:0] hold_q;
   logic [N_CH-1:0]   rr_pick_w;
   logic [IDX_W-1:0]  rr_idx_w;
   logic              others;

   assign others = |(req & ~grant_q);

   rr_pick #(
      .N_CH  (N_CH),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req_i      (req),
      .last_ptr_i (last_ptr_q),
      .pick_o     (rr_pick_w),
      .idx_o      (rr_idx_w)
   );
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         conflict_q <= 1'b0;
         cnt_q      <= '0;
`ifdef FUNC_ARB_RR_EN
         last_ptr_q <= IDX_W'(N_CH - 1);
         hold_q     <= '0;
`endif
      end else begin
         conflict_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (req != '0 && !multi) begin
                  grant_q <= req;
                  state_q <= ST_GRANT;
`ifdef FUNC_ARB_RR_EN
                  last_ptr_q <= rr_idx_w;
                  hold_q     <= '0;
`endif
               end else if (multi) begin
                  conflict_q <= 1'b1;
                  if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
`ifdef FUNC_ARB_RR_EN
                  grant_q    <= rr_pick_w;
                  last_ptr_q <= rr_idx_w;
                  hold_q     <= '0;
                  state_q    <= ST_GRANT;
`else
                  state_q    <= ST_BLOCK;
`endif
               end
            end
            ST_GRANT: begin
               if (!own_req) begin
                  grant_q <= '0;
                  state_q <= ST_IDLE;
`ifdef FUNC_ARB_RR_EN
                  hold_q  <= '0;
               end else if (others) begin
                  // hand over on the cycle the hold count would hit HOLD_MAX
                  if (int'(hold_q) + 1 >= HOLD_MAX) begin
                     grant_q    <= rr_pick_w;
                     last_ptr_q <= rr_idx_w;
                     hold_q     <= '0;
                  end else begin
                     hold_q <= hold_q + 1'b1;
                  end
               end else begin
                  hold_q <= '0;
`endif
               end
            end
            ST_BLOCK: begin
               grant_q <= '0;
               if (!multi) state_q <= ST_IDLE;
            end
            default: begin
               grant_q <= '0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign grant_o        = grant_q;
   assign busy_o         = |grant_q;
   assign conflict_o     = conflict_q;
   assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_func_grant_arbiter.sv
// Directed self-checking bench for func_grant_arbiter (three instances).
// Round-robin expectations apply when FUNC_ARB_RR_EN is defined.
module tb_func_grant_arbiter;

   logic        clk;
   logic        rst;
   logic [5:0]  mode_a;
   logic [5:0]  mode_s;
   logic [15:0] mode_n;

   logic [1:0]  grant_a;
   logic        busy_a;
   logic        conf_a;
   logic [7:0]  cnt_a;

   logic [1:0]  grant_s;
   logic        busy_s;
   logic        conf_s;
   logic [1:0]  cnt_s;

   logic [3:0]  grant_n;
   logic        busy_n;
   logic        conf_n;
   logic [7:0]  cnt_n;

   int n_cmp;
   int n_err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   func_grant_arbiter #(
      .N_CH(2), .MODE_W(3), .FUNC_CODE(3'b010),
      .HOLD_MAX(3), .CNT_W(8)
   ) u_dut (
      .clk(clk), .rst(rst), .mode_i(mode_a),
      .grant_o(grant_a), .busy_o(busy_a),
      .conflict_o(conf_a), .conflict_cnt_o(cnt_a)
   );

   func_grant_arbiter #(
      .N_CH(2), .MODE_W(3), .FUNC_CODE(3'b010),
      .HOLD_MAX(3), .CNT_W(2)
   ) u_sat (
      .clk(clk), .rst(rst), .mode_i(mode_s),
      .grant_o(grant_s), .busy_o(busy_s),
      .conflict_o(conf_s), .conflict_cnt_o(cnt_s)
   );

   func_grant_arbiter #(
      .N_CH(4), .MODE_W(4), .FUNC_CODE(4'h9),
      .HOLD_MAX(15), .CNT_W(8)
   ) u_n4 (
      .clk(clk), .rst(rst), .mode_i(mode_n),
      .grant_o(grant_n), .busy_o(busy_n),
      .conflict_o(conf_n), .conflict_cnt_o(cnt_n)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp  = 0;
      n_err  = 0;
      rst    = 1'b1;
      mode_a = '0;
      mode_s = '0;
      mode_n = '0;
      step();
      step();
      rst = 1'b0;
      chk("rst_grant", 32'(grant_a), 32'h0);
      chk("rst_busy", 32'(busy_a), 32'h0);
      chk("rst_conf", 32'(conf_a), 32'h0);
      chk("rst_cnt", 32'(cnt_a), 32'h0);

      // single request: ch0=010, ch1=101
      mode_a = {3'b101, 3'b010};
      step();
      chk("single_grant", 32'(grant_a), 32'h1);
      chk("single_busy", 32'(busy_a), 32'h1);
      mode_a = {3'b101, 3'b000};
      step();
      chk("release_grant", 32'(grant_a), 32'h0);
      chk("release_cnt", 32'(cnt_a), 32'h0);
      step();

`ifdef FUNC_ARB_RR_EN
      rst = 1'b1;
      step();
      rst = 1'b0;
      mode_a = {3'b010, 3'b010};
      step();
      chk("rr_conf", 32'(conf_a), 32'h1);
      chk("rr_cnt", 32'(cnt_a), 32'h1);
      chk("rr_grant0", 32'(grant_a), 32'h1);
      step();
      chk("rr_pulse_end", 32'(conf_a), 32'h0);
      chk("rr_hold1", 32'(grant_a), 32'h1);
      step();
      chk("rr_hold2", 32'(grant_a), 32'h1);
      step();
      chk("rr_handover", 32'(grant_a), 32'h2);
      chk("rr_no_cnt", 32'(cnt_a), 32'h1);
      mode_a = {3'b000, 3'b010};
      step();
      chk("rr_rel_gap", 32'(grant_a), 32'h0);
      step();
      chk("rr_regrant", 32'(grant_a), 32'h1);
`else
      mode_a = {3'b010, 3'b010};
      step();
      chk("blk_conf", 32'(conf_a), 32'h1);
      chk("blk_cnt", 32'(cnt_a), 32'h1);
      chk("blk_grant0", 32'(grant_a), 32'h0);
      step();
      chk("blk_pulse_end", 32'(conf_a), 32'h0);
      chk("blk_grant1", 32'(grant_a), 32'h0);
      chk("blk_cnt_hold", 32'(cnt_a), 32'h1);
      mode_a = {3'b111, 3'b010};
      step();
      chk("blk_exit", 32'(grant_a), 32'h0);
      step();
      chk("blk_regrant", 32'(grant_a), 32'h1);
`endif

      // reset while ch1 owns the grant
      mode_a = '0;
      step();
      step();
      mode_a = {3'b010, 3'b000};
      step();
      chk("pre_rst_grant", 32'(grant_a), 32'h2);
      rst    = 1'b1;
      mode_a = {3'b010, 3'b010};
      step();
      rst = 1'b0;
      chk("mid_rst_grant", 32'(grant_a), 32'h0);
      chk("mid_rst_busy", 32'(busy_a), 32'h0);
      chk("mid_rst_conf", 32'(conf_a), 32'h0);
      chk("mid_rst_cnt", 32'(cnt_a), 32'h0);
      step();
      chk("post_rst_conf", 32'(conf_a), 32'h1);
      chk("post_rst_cnt", 32'(cnt_a), 32'h1);
`ifdef FUNC_ARB_RR_EN
      chk("post_rst_grant", 32'(grant_a), 32'h1);
`else
      chk("post_rst_grant", 32'(grant_a), 32'h0);
`endif
      mode_a = '0;

      // counter saturation with CNT_W=2
      for (int k = 1; k <= 5; k++) begin
         mode_s = {3'b010, 3'b010};
         step();
         chk($sformatf("sat_conf%0d", k), 32'(conf_s), 32'h1);
         chk($sformatf("sat_cnt%0d", k), 32'(cnt_s),
             (k < 3) ? 32'(k) : 32'h3);
         mode_s = '0;
         step();
      end

      // four channels, FUNC_CODE=9
      mode_n = 16'h0900;
      step();
      chk("n4_grant", 32'(grant_n), 32'h4);
      chk("n4_conf", 32'(conf_n), 32'h0);
      mode_n = 16'h9900;
      step();
      chk("n4_keep", 32'(grant_n), 32'h4);
      chk("n4_noconf", 32'(conf_n), 32'h0);
      step();
      chk("n4_keep2", 32'(grant_n), 32'h4);
      chk("n4_cnt", 32'(cnt_n), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/func_grant_arbiter.md
# func_grant_arbiter

Parametrised, registered successor to the two-channel "functionality 2" exclusivity check in the controller. It watches `N_CH` channels, each presenting a `MODE_W`-bit mode code, and decides which channel currently owns the target functionality `FUNC_CODE`. Ownership is held until the owner releases it, and conflicts are counted. It sits between the per-user mode selectors and the actuator that executes the functionality.

## Interface
Parameters:
- `N_CH`, 2: number of requesting channels (2..16).
- `MODE_W`, 3: width of each channel's mode code.
- `FUNC_CODE`, 3'b010: mode value that requests the functionality.
- `HOLD_MAX`, 15: maximum consecutive grant cycles while another channel waits. Used only with round-robin.
- `CNT_W`, 8: width of the conflict counter.

Ports:
- `clk`: input, 1. Single clock, rising edge.
- `rst`: input, 1. Synchronous, active-high reset.
- `mode_i`: input, N_CH*MODE_W. Channel i's code is in bits [i*MODE_W +: MODE_W].
- `grant_o`: output, N_CH. One-hot or zero; marks the owner channel.
- `busy_o`: output, 1. High when any grant is active.
- `conflict_o`: output, 1. One-cycle pulse when a new conflict is detected.
- `conflict_cnt_o`: output, CNT_W. Saturating count of conflicts.

## Operation
- `req[i]` is high when `mode_i` slice i equals `FUNC_CODE`. It is combinational, with no input registering.
- The FSM has three states: IDLE, GRANT, BLOCK.
- **IDLE**
  - req==0: stay in IDLE.
  - Exactly one req bit set: grant that channel and go to GRANT.
  - Two or more req bits set: this is a conflict. Pulse `conflict_o` and increment the counter.
    - Without the macro, go to BLOCK.
    - With the macro, grant the first requester after `last_ptr` in round-robin order and go to GRANT.
- **GRANT**
  - Owner's req stays high: keep the grant. The hold counter increments only while some other req bit is high, and resets to 0 otherwise.
  - Owner's req drops: clear the grant and go to IDLE. A new grant can be issued no earlier than the next evaluation in IDLE.
  - With the macro, if the hold counter reaches `HOLD_MAX` while another channel requests, pass the grant to the next requester in round-robin order and reset the hold counter. No conflict is counted for this handover.
  - Requests from non-owners never create conflicts in GRANT.
- **BLOCK**
  - `grant_o` stays 0.
  - When popcount(req) ≤ 1, go to IDLE. A single remaining requester is granted on the following evaluation.
  - No further conflict pulses are raised while in BLOCK.
- `last_ptr` updates to the granted channel index on every grant.
- `conflict_cnt_o` saturates at all-ones and never wraps.

## Timing
- All outputs are registered. A request pattern sampled at edge k appears on `grant_o`/`conflict_o` after edge k, i.e. one cycle of latency.
- Owner release sampled at edge k: `grant_o` reads 0 after edge k. The earliest regrant is after edge k+1.
- Reset values:
  - `grant_o` = 0, `busy_o` = 0, `conflict_o` = 0, `conflict_cnt_o` = 0.
  - State = IDLE, `last_ptr` = N_CH-1, so channel 0 wins first, and hold counter = 0.
- `rst` asserted mid-grant or mid-BLOCK: at that edge everything returns to its reset value. Requests present during reset are ignored for that cycle.
- `busy_o` equals |`grant_o`, taken from the same register stage.

## Configuration
- `FUNC_ARB_RR_EN` defined: conflicts in IDLE resolve by round-robin grant, and the `HOLD_MAX` fairness handover in GRANT is active. BLOCK is never entered.
- `FUNC_ARB_RR_EN` undefined: conflicts enter BLOCK and no grant is issued until at most one requester remains. `HOLD_MAX` is ignored and the hold counter may be removed.
- The conflict pulse and counter behave identically in both builds.

## Structure
- The shared package `func_arb_pkg` holds:
  - The state enum (IDLE/GRANT/BLOCK).
  - The default `FUNC_CODE`.
  - A popcount-≤1 helper function.
- Sub-module `rr_pick`: a combinational round-robin selector. Inputs are req[N_CH] and last_ptr; outputs are a one-hot pick and its index. It is instantiated only when `FUNC_ARB_RR_EN` is defined.

## Test plan
- **Single request:** with N_CH=2, MODE_W=3, set ch0=010 and ch1=101. `grant_o`=01 one cycle later. Set ch0=000: `grant_o`=00 one cycle later and `conflict_cnt_o`=0.
- **Conflict, no macro:** ch0=ch1=010 from IDLE. One-cycle `conflict_o` pulse, cnt=1, `grant_o`=00 held. Set ch1=111: `grant_o`=01 two cycles later.
- **Conflict, `FUNC_ARB_RR_EN`:** both 010 after reset gives `grant_o`=01 and cnt=1. With HOLD_MAX=3, `grant_o` becomes 10 after 3 waiting cycles. Then release ch1: `grant_o`=01.
- **Saturation:** CNT_W=2, force 5 conflicts by alternating 010/010 and 000/000. `conflict_cnt_o` stops at 3.
- **Reset mid-grant:** assert `rst` for one cycle while `grant_o`=10. All outputs are 0 next cycle. With the macro and both channels requesting, the first post-reset grant goes to ch0.
- **N_CH=4, MODE_W=4, FUNC_CODE=4'h9:** only ch2=9 gives `grant_o`=0100. Adding ch3=9 while ch2 holds causes no conflict pulse and no grant change.
